top_gng: RTL and testbench

- Free-running Gaussian noise generator (GNG).
- Emits two independent, approximately normal 16-bit two's-complement samples, x0 and x1, every clock.
- Uniform source: four Tausworthe (taus88) 32-bit URNGs. Gaussian shaping by central limit theorem (sum of 8 bytes).
- Top-level noise source; no input handshake; output valid every cycle after reset.

---
 rtl/gng_pkg.sv | 40 ++++
 rtl/taus88_urng.sv | 28 ++
 rtl/top_gng.sv | 69 ++++++
 tb/tb_top_gng.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gng_pkg.sv
// Gaussian noise generator package: widths, CLT constants, default seeds,
// the taus88 state type and its next-state step.
package gng_pkg;

  localparam int unsigned URNG_W     = 32;
  localparam int unsigned OUT_W      = 16;
  localparam int unsigned CLT_N      = 8;     // bytes summed per sample
  localparam int unsigned CLT_OFFSET = 1020;  // CLT_N * 255 / 2
  localparam int unsigned OUT_SHIFT  = 4;
  localparam int unsigned SUM_W      = 11;    // holds 0..2040
  localparam int unsigned DIFF_W     = OUT_W - OUT_SHIFT;

  localparam logic [3*URNG_W-1:0] SEED0_DEF = 96'h12345678_9ABCDEF0_0F1E2D3C;
  localparam logic [3*URNG_W-1:0] SEED1_DEF = 96'h2468ACE0_13579BDF_DEADBEEF;
  localparam logic [3*URNG_W-1:0] SEED2_DEF = 96'hCAFEBABE_0BADF00D_87654321;
  localparam logic [3*URNG_W-1:0] SEED3_DEF = 96'hFEEDFACE_55AA55AA_C0FFEE11;

  // Packed so that a 96-bit seed {s1,s2,s3} maps straight onto the state.
  typedef struct packed {
    logic [URNG_W-1:0] s1;
    logic [URNG_W-1:0] s2;
    logic [URNG_W-1:0] s3;
  } taus_state_t;

  // One taus88 step; all shifts are logical.
  function automatic taus_state_t taus88_step(input taus_state_t s);
    taus_state_t       n;
    logic [URNG_W-1:0] b1;
    logic [URNG_W-1:0] b2;
    logic [URNG_W-1:0] b3;
    b1   = ((s.s1 << 13) ^ s.s1) >> 19;
    n.s1 = ((s.s1 & 32'hFFFF_FFFE) << 12) ^ b1;
    b2   = ((s.s2 << 2) ^ s.s2) >> 25;
    n.s2 = ((s.s2 & 32'hFFFF_FFF8) << 4) ^ b2;
    b3   = ((s.s3 << 3) ^ s.s3) >> 11;
    n.s3 = ((s.s3 & 32'hFFFF_FFF0) << 17) ^ b3;
    return n;
  endfunction

endpackage

// File: rtl/taus88_urng.sv
// taus88 uniform random number generator.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, loads SEED
//   u     - 32-bit uniform output, combinational from the registered state
module taus88_urng
  import gng_pkg::*;
#(
  parameter logic [3*URNG_W-1:0] SEED = SEED0_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic [URNG_W-1:0] u
);

  taus_state_t r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= taus_state_t'(SEED);
    end else begin
      r_state <= taus88_step(r_state);
    end
  end

  assign u = r_state.s1 ^ r_state.s2 ^ r_state.s3;

endmodule

// File: rtl/top_gng.sv
// Free-running Gaussian noise generator. Two taus88 URNGs per channel feed a
// central-limit adder tree (sum of 8 bytes), which is centred and scaled into
// a registered 16-bit two's-complement sample every clock.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, clears outputs and reseeds URNGs
//   x0    - Gaussian sample 0 (URNG0/URNG1)
//   x1    - Gaussian sample 1 (URNG2/URNG3)
module top_gng
  import gng_pkg::*;
#(
  parameter logic [3*URNG_W-1:0] SEED0 = SEED0_DEF,
  parameter logic [3*URNG_W-1:0] SEED1 = SEED1_DEF,
  parameter logic [3*URNG_W-1:0] SEED2 = SEED2_DEF,
  parameter logic [3*URNG_W-1:0] SEED3 = SEED3_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] x0,
  output logic [OUT_W-1:0] x1
);

  // Byte-sum adder tree, centring, and scaling. 11-bit sum cannot overflow,
  // and the 12-bit difference (-1020..1020) always fits without saturation.
  function automatic logic [OUT_W-1:0] clt_shape(input logic [URNG_W-1:0] ua,
                                                 input logic [URNG_W-1:0] ub);
    logic [2*URNG_W-1:0] w_all;
    logic [8:0]          l1 [4];
    logic [9:0]          l2 [2];
    logic [SUM_W-1:0]    sum;
    logic [DIFF_W-1:0]   diff;
    w_all = {ub, ua};
    for (int i = 0; i < 4; i++) begin
      l1[i] = {1'b0, w_all[16*i +: 8]} + {1'b0, w_all[16*i+8 +: 8]};
    end
    for (int j = 0; j < 2; j++) begin
      l2[j] = {1'b0, l1[2*j]} + {1'b0, l1[2*j+1]};
    end
    sum  = {1'b0, l2[0]} + {1'b0, l2[1]};
    diff = {1'b0, sum} - DIFF_W'(CLT_OFFSET);
    return {diff, {OUT_SHIFT{1'b0}}};
  endfunction

  logic [URNG_W-1:0] w_u0;
  logic [URNG_W-1:0] w_u1;
  logic [URNG_W-1:0] w_u2;
  logic [URNG_W-1:0] w_u3;
  logic [OUT_W-1:0]  r_x0;
  logic [OUT_W-1:0]  r_x1;

  taus88_urng #(.SEED(SEED0)) u_urng0 (.clk(clk), .reset(reset), .u(w_u0));
  taus88_urng #(.SEED(SEED1)) u_urng1 (.clk(clk), .reset(reset), .u(w_u1));
  taus88_urng #(.SEED(SEED2)) u_urng2 (.clk(clk), .reset(reset), .u(w_u2));
  taus88_urng #(.SEED(SEED3)) u_urng3 (.clk(clk), .reset(reset), .u(w_u3));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x0 <= '0;
      r_x1 <= '0;
    end else begin
      r_x0 <= clt_shape(w_u0, w_u1);
      r_x1 <= clt_shape(w_u2, w_u3);
    end
  end

  assign x0 = r_x0;
  assign x1 = r_x1;

endmodule

// File: tb/tb_top_gng.sv
// Self-checking bench for top_gng: a reference taus88+CLT model pushes the
// expected sample at every active edge, a monitor pops and compares on the
// falling edge. Also checks reset, first sample, range, statistics, replay
// and the equal-seed instance.
module tb_top_gng;

  localparam logic [95:0] TSEED0 = 96'h12345678_9ABCDEF0_0F1E2D3C;
  localparam logic [95:0] TSEED1 = 96'h2468ACE0_13579BDF_DEADBEEF;
  localparam logic [95:0] TSEED2 = 96'hCAFEBABE_0BADF00D_87654321;
  localparam logic [95:0] TSEED3 = 96'hFEEDFACE_55AA55AA_C0FFEE11;
  localparam int          NRUN   = 10000;
  localparam int          NREP   = 500;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x0, x1, ex0, ex1;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          phase    = 0;
  int          cnt      = 0;
  int          q0[$];
  int          q1[$];
  int          hist0 [NREP];
  int          hist1 [NREP];
  logic [31:0] m_s [4][3];
  real         sm0 = 0.0, sm1 = 0.0, sq0 = 0.0, sq1 = 0.0, sx01 = 0.0;
  int          nsamp = 0, pos0 = 0, neg0 = 0, pos1 = 0, neg1 = 0;

  always #5 clk = ~clk;

  top_gng #(.SEED0(TSEED0), .SEED1(TSEED1), .SEED2(TSEED2), .SEED3(TSEED3)) u_dut (
    .clk  (clk),
    .reset(reset),
    .x0   (x0),
    .x1   (x1)
  );

  top_gng #(.SEED0(TSEED0), .SEED1(TSEED1), .SEED2(TSEED0), .SEED3(TSEED1)) u_dut_eq (
    .clk  (clk),
    .reset(reset),
    .x0   (ex0),
    .x1   (ex1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_real(input string name, input real v, input real lo, input real hi);
    n_checks++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %f expected in [%f,%f]", name, v, lo, hi);
    end
  endtask

  // Reference model written directly from the taus88 recurrences.
  function automatic logic [31:0] t1(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 13) ^ s) >> 19;
    return ((s & 32'hFFFFFFFE) << 12) ^ b;
  endfunction
  function automatic logic [31:0] t2(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 2) ^ s) >> 25;
    return ((s & 32'hFFFFFFF8) << 4) ^ b;
  endfunction
  function automatic logic [31:0] t3(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 3) ^ s) >> 11;
    return ((s & 32'hFFFFFFF0) << 17) ^ b;
  endfunction

  function automatic int shape(input logic [31:0] a, input logic [31:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(a[8*i +: 8]) + int'(b[8*i +: 8]);
    return (s - 1020) * 16;
  endfunction

  task automatic load_one(input int k, input logic [95:0] sd);
    m_s[k][0] = sd[95:64];
    m_s[k][1] = sd[63:32];
    m_s[k][2] = sd[31:0];
  endtask

  function automatic logic [31:0] mu(input int k);
    return m_s[k][0] ^ m_s[k][1] ^ m_s[k][2];
  endfunction

  // Stimulus side of the scoreboard: expected sample for each active edge.
  always @(posedge clk) begin
    if (reset) begin
      load_one(0, TSEED0);
      load_one(1, TSEED1);
      load_one(2, TSEED2);
      load_one(3, TSEED3);
    end else begin
      q0.push_back(shape(mu(0), mu(1)));
      q1.push_back(shape(mu(2), mu(3)));
      for (int k = 0; k < 4; k++) begin
        m_s[k][0] = t1(m_s[k][0]);
        m_s[k][1] = t2(m_s[k][1]);
        m_s[k][2] = t3(m_s[k][2]);
      end
    end
  end

  // Monitor side: compare whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    int e0, e1, v0, v1;
    if (reset) begin
      cnt = 0;
    end else if (q0.size() > 0) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      v0 = $signed(x0);
      v1 = $signed(x1);
      check("x0_model", v0, e0);
      check("x1_model", v1, e1);
      check("eq_x1_vs_x0", $signed(ex1), $signed(ex0));
      check("eq_x0_vs_model", $signed(ex0), e0);
      if (cnt == 0) begin
        check("first_x0", v0, 5344);
        check("first_x1", v1, -4288);
      end
      check("x0_range", (v0 >= -16320 && v0 <= 16320) ? 1 : 0, 1);
      check("x1_range", (v1 >= -16320 && v1 <= 16320) ? 1 : 0, 1);
      check("x0_lsbs", int'(x0[3:0]), 0);
      check("x1_lsbs", int'(x1[3:0]), 0);
      if (phase == 0) begin
        if (cnt < NREP) begin
          hist0[cnt] = v0;
          hist1[cnt] = v1;
        end
        nsamp++;
        sm0  += real'(v0);
        sm1  += real'(v1);
        sq0  += real'(v0) * real'(v0);
        sq1  += real'(v1) * real'(v1);
        sx01 += real'(v0) * real'(v1);
        if (v0 > 0) pos0++;
        if (v0 < 0) neg0++;
        if (v1 > 0) pos1++;
        if (v1 < 0) neg1++;
      end else if (cnt < NREP) begin
        check("replay_x0", v0, hist0[cnt]);
        check("replay_x1", v1, hist1[cnt]);
      end
      cnt++;
    end
  end

  initial begin
    real m0, m1, sd0, sd1, r;
    reset = 1'b1;
    #7;
    check("reset_x0", $signed(x0), 0);
    check("reset_x1", $signed(x1), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (NRUN) @(negedge clk);
    // Asynchronous assert between edges must clear outputs immediately.
    #2 reset = 1'b1;
    #1;
    check("async_reset_x0", $signed(x0), 0);
    check("async_reset_x1", $signed(x1), 0);
    phase = 1;
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (NREP + 100) @(negedge clk);

    check("sample_count", nsamp, NRUN);
    if (nsamp > 0) begin
      m0  = sm0 / nsamp;
      m1  = sm1 / nsamp;
      sd0 = $sqrt(sq0 / nsamp - m0 * m0);
      sd1 = $sqrt(sq1 / nsamp - m1 * m1);
      r   = (sx01 / nsamp - m0 * m1) / (sd0 * sd1);
      check_real("x0_mean", m0, -150.0, 150.0);
      check_real("x1_mean", m1, -150.0, 150.0);
      check_real("x0_sigma", sd0, 3170.0, 3510.0);
      check_real("x1_sigma", sd1, 3170.0, 3510.0);
      check_real("x0_x1_corr", r, -0.05, 0.05);
    end
    check_real("x0_pos_count", real'(pos0), 1.0, 1.0e9);
    check_real("x0_neg_count", real'(neg0), 1.0, 1.0e9);
    check_real("x1_pos_count", real'(pos1), 1.0, 1.0e9);
    check_real("x1_neg_count", real'(neg1), 1.0, 1.0e9);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
